// File: rtl/led_fader_if.sv
// LED fader port bundle: pattern request in, dimmed pins and busy out.
// The master side drives the pattern; the fader is the slave.
interface led_fader_if;
  logic [5:0] pattern_in;
  logic [5:0] led;
  logic       busy;

  modport master (
    output pattern_in,
    input  led,
    input  busy
  );

  modport slave (
    input  pattern_in,
    output led,
    output busy
  );
endinterface

// File: rtl/led_fader.sv
// Six-channel LED fader: each channel ramps its 8-bit brightness toward
// full-on or off one step per prescaler tick, and PWM-dims its pin.
module led_fader #(
  parameter int unsigned RAMP_DIV   = 52734,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  led_fader_if.slave  bus
);

  localparam logic [23:0] PRE_MAX = 24'(RAMP_DIV - 1);

  logic [5:0]  pat_q;
  logic [7:0]  lvl_q [6];
  logic [7:0]  lvl_d [6];
  logic [23:0] pre_q;
  logic [23:0] pre_d;
  logic [7:0]  pwm_q;
  logic [5:0]  led_q;
  logic [5:0]  led_d;
  logic [5:0]  diff;
  logic        tick;

  assign tick  = (pre_q == PRE_MAX);
  assign pre_d = tick ? 24'd0 : pre_q + 24'd1;

  // diff doubles as the saturation guard: no step once the target is met
  always_comb begin
    diff  = '0;
    led_d = '0;
    for (int i = 0; i < 6; i++) begin
      diff[i]  = (lvl_q[i] != {8{pat_q[i]}});
      lvl_d[i] = lvl_q[i];
      if (tick && diff[i]) begin
        lvl_d[i] = pat_q[i] ? lvl_q[i] + 8'd1
                            : lvl_q[i] - 8'd1;
      end
      led_d[i] = ((lvl_q[i] == 8'hFF) ||
                  (lvl_q[i] > pwm_q)) ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      pre_q <= '0;
      pwm_q <= '0;
      led_q <= {6{ACTIVE_LOW}};
      for (int i = 0; i < 6; i++) begin
        lvl_q[i] <= '0;
      end
    end else begin
      pat_q <= bus.pattern_in;
      pre_q <= pre_d;
      pwm_q <= pwm_q + 8'd1;
      led_q <= led_d;
      for (int i = 0; i < 6; i++) begin
        lvl_q[i] <= lvl_d[i];
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = |diff;

endmodule

// File: tb/tb_led_fader.sv
// Randomised scoreboard bench for led_fader (RAMP_DIV=4, active-low pins).
// A per-edge brightness model predicts led/busy; a monitor compares them.
module tb_led_fader;

  localparam int D = 4;

  logic clk;
  logic rst;

  led_fader_if bus ();

  led_fader #(
    .RAMP_DIV   (D),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] exp_q [$];

  // model state: brightness as plain integers, edges counted since reset
  int         m_lvl [6];
  logic [5:0] m_pat;
  int         m_k;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name,
                     input logic [6:0] act,
                     input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b expected=%b",
               name, $time, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d expected %0d..%0d",
               name, act, lo, hi);
    end
  endtask

  // reference model: one step per rising edge
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pat = '0;
        m_k   = 0;
        for (int i = 0; i < 6; i++) m_lvl[i] = 0;
        exp_q.delete();
      end else begin
        logic [5:0] e_led;
        logic       e_busy;
        int         pwm;
        m_k++;
        pwm = (m_k - 1) % 256;
        for (int i = 0; i < 6; i++) begin
          e_led[i] = !(m_lvl[i] == 255 ||
                       (m_lvl[i] != 0 && m_lvl[i] > pwm));
        end
        if (m_k % D == 0) begin
          for (int i = 0; i < 6; i++) begin
            if (m_pat[i] && m_lvl[i] < 255) m_lvl[i]++;
            else if (!m_pat[i] && m_lvl[i] > 0) m_lvl[i]--;
          end
        end
        m_pat  = bus.pattern_in;
        e_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
          if (m_lvl[i] != (m_pat[i] ? 255 : 0)) e_busy = 1'b1;
        end
        exp_q.push_back({e_led, e_busy});
      end
    end
  end

  // monitor: samples on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_hold", {bus.led, bus.busy}, 7'b1111110);
      end else if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_underflow at %0t", $time);
      end else begin
        chk("sb_led_busy", {bus.led, bus.busy},
            exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] p);
    @(negedge clk);
    bus.pattern_in = p;
  endtask

  task automatic wait_idle(input string name, input int lo,
                           input int hi, input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < bound);
    chk_rng(name, n, lo, hi);
  endtask

  task automatic async_pulse();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", {bus.led, bus.busy}, 7'b1111110);
    #1 rst = 1'b0;
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    bus.pattern_in = 6'b111111;
    cyc(4);
    @(negedge clk);
    #2 rst = 1'b0;

    // full ramp up from reset: busy falls after 1020 edges
    wait_idle("ramp_up_time", 1015, 1025, 2000);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!bus.led[2]) n++;
    end
    chk_rng("full_on_duty", n, 256, 256);

    // fade down channel 0
    drive(6'b000001);
    wait_idle("shed_others", 1015, 1025, 2000);
    drive(6'b000000);
    wait_idle("fade_down_time", 1015, 1025, 2000);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.led[0]) n++;
    end
    chk_rng("stay_off", n, 300, 300);

    // reversal: up for 40 cycles then back down
    drive(6'b001000);
    cyc(39);
    drive(6'b000000);
    wait_idle("reversal_time", 36, 44, 200);

    // async reset mid-ramp
    drive(6'b111111);
    cyc(100);
    async_pulse();
    cyc(300);

    // shifter-style walk
    for (int s = 0; s <= 6; s++) begin
      drive(6'(6'b111111 << s));
      cyc(2000);
    end
    drive(6'b111111);
    cyc(2000);

    // random patterns with occasional reset pulses
    for (int s = 0; s < 30; s++) begin
      drive(6'($urandom));
      cyc($urandom_range(1, 700));
      if ($urandom_range(0, 9) == 0) async_pulse();
    end

    cyc(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter RAMP_DIV, default 52734, clock cycles between brightness ramp steps; legal range 1..2^24-1.
REQ-002 Parameter ACTIVE_LOW, default 1; 1 = LED pin driven low to light, 0 = driven high to light.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pattern_in  input  6  per-LED on/off request from the upstream LED pattern shifter, synchronous to clk; 1 = on.
REQ-006 led  output  6  PWM-dimmed LED pins, polarity per ACTIVE_LOW.
REQ-007 busy  output  1  high while any channel's brightness differs from its target.

Function
REQ-008 The block SHALL register pattern_in once into pat_q; all targets derive from pat_q, giving 1 cycle of input latency.
REQ-009 The target brightness per channel SHALL be 255 when its pat_q bit is 1, and 0 when it is 0.
REQ-010 The block SHALL hold one 8-bit brightness level per channel: lvl[0..5].
REQ-011 A prescaler SHALL count 0..RAMP_DIV-1 and assert a one-cycle ramp tick on the cycle it wraps to 0; with RAMP_DIV=1 the tick is asserted every cycle.
REQ-012 On a ramp tick, each lvl SHALL step by exactly 1 toward its target.
REQ-013 Brightness levels SHALL saturate: never increment past 255, never decrement below 0, never wrap.
REQ-014 Between ticks, lvl SHALL hold its value.
REQ-015 A free-running 8-bit PWM counter pwm_cnt SHALL increment every cycle and wrap 255->0.
REQ-016 A channel SHALL be lit when lvl > pwm_cnt, except that lvl==255 SHALL be lit on every cycle (full-on) and lvl==0 SHALL never be lit.
REQ-017 The led outputs SHALL be registered, giving 1 cycle of latency from lvl/pwm_cnt to the pin; with ACTIVE_LOW=1, lit = 0.
REQ-018 A pattern change mid-ramp SHALL reverse the ramp direction from the current lvl at the next tick, with no jump in level.
REQ-019 When a pat_q update and a tick occur in the same cycle, the step SHALL use the pat_q value held before that edge.
REQ-020 busy SHALL be combinational from registered state: busy = OR over channels of (lvl != target).
REQ-021 Full-scale ramp time SHALL be 255*RAMP_DIV cycles, nominally 0.49 s at 27 MHz with default parameters.

Reset
REQ-022 On rst assertion, independent of clk, the block SHALL immediately clear pat_q, lvl[0..5], the prescaler and pwm_cnt to 0.
REQ-023 During reset, led SHALL read all-unlit: 6'b111111 when ACTIVE_LOW=1, 6'b000000 when ACTIVE_LOW=0.
REQ-024 During reset, busy SHALL be 0.
REQ-025 After rst deassertion, the first prescaler tick SHALL occur RAMP_DIV cycles later.
REQ-026 Reset asserted mid-ramp SHALL abort the ramp; there is no resumption of the prior level.

Verification (bench uses RAMP_DIV=4, ACTIVE_LOW=1)
REQ-027 Reset check: hold rst with pattern_in=6'b111111 -> led=6'b111111, busy=0; release rst -> lvl[i] reaches 255 after 1020 cycles ±5 and busy falls the same cycle.
REQ-028 Fade down: start at steady pattern_in=6'b000001, then drive 6'b000000 -> lvl[0] decrements once per 4 cycles, reaches 0, and led[0] then stays 1 indefinitely.
REQ-029 Duty check: force lvl[2] to 64 (pattern toggled at the right time) -> led[2] is low for exactly 64 of every 256 cycles; with lvl=255, led[2] is low on all 256 cycles.
REQ-030 Reversal: toggle pattern_in bit 3 to 1 for 40 cycles, then to 0 -> lvl[3] peaks at 10 and returns to 0 with no discontinuity; busy stays 1 until lvl[3]=0.
REQ-031 Async reset: pulse rst for less than one clk period mid-ramp, between edges -> led goes to 6'b111111 before the next edge and all lvl read 0.
REQ-032 Shifter pattern: drive pattern_in 111111, 111110, 111100, ... 000000, 111111, one step per 2000 cycles -> each channel's lvl follows its bit independently, and no lvl ever exceeds 255 or wraps below 0.
